// File: rtl/prog_loader_pkg.sv
// Shared types and header-field constants for the program/data loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2,
        RUN  = 2'd3
    } state_e;

    localparam int TGT_BIT = 31;
    localparam int GO_BIT  = 30;
    localparam int CNT_HI  = 23;
    localparam int CNT_LO  = 8;
    localparam int CNT_W   = CNT_HI - CNT_LO + 1;

    localparam logic MEM_SEL_IMEM = 1'b0;
    localparam logic MEM_SEL_DMEM = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Stream-in handshake and shared memory write port of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Framed stream loader into IMem/DMem; holds the CPU in reset until a go frame lands.
// Optional trailer checksum check: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    prog_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             load_error,
    output logic [CNT_W-1:0] words_loaded
);

    state_e            state_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic              mem_sel_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              tgt_r;
    logic              go_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  remain_r;
    logic [CNT_W-1:0]  words_r;
    logic              release_r;
    logic              cpu_hold_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;
    logic              err_r;
`endif

    logic              accept_s;
    logic [DATA_W-1:0] word_s;
    logic [CNT_W-1:0]  hdr_cnt_s;

    assign word_s    = bus.in_data;
    assign accept_s  = bus.in_valid && in_ready_r;
    assign hdr_cnt_s = word_s[CNT_HI:CNT_LO];

    // Frame FSM, registered write port, and two-stage CPU release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= HDR;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_sel_r   <= MEM_SEL_IMEM;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            tgt_r       <= 1'b0;
            go_r        <= 1'b0;
            addr_r      <= '0;
            remain_r    <= '0;
            words_r     <= '0;
            release_r   <= 1'b0;
            cpu_hold_r  <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r       <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            mem_we_r   <= 1'b0;
            in_ready_r <= (state_r != RUN);
            // release lags RUN entry so the final write lands before the CPU runs
            release_r  <= (state_r == RUN);
            cpu_hold_r <= !release_r;
            case (state_r)
                HDR: begin
                    if (accept_s) begin
                        tgt_r    <= word_s[TGT_BIT];
                        go_r     <= word_s[GO_BIT];
                        addr_r   <= word_s[ADDR_W-1:0];
                        remain_r <= hdr_cnt_s;
                        words_r  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r    <= '0;
`endif
                        if (hdr_cnt_s != '0) begin
                            state_r <= DATA;
                        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_r <= CSUM;
`else
                            if (word_s[GO_BIT]) begin
                                state_r    <= RUN;
                                in_ready_r <= 1'b0;
                            end else begin
                                state_r <= HDR;
                            end
`endif
                        end
                    end else begin
                        state_r <= HDR;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_sel_r   <= tgt_r ? MEM_SEL_DMEM : MEM_SEL_IMEM;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= word_s;
                        addr_r      <= addr_r + ADDR_W'(1);
                        words_r     <= sat_inc(words_r);
                        remain_r    <= remain_r - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r       <= sum_r + word_s;
`endif
                        if (remain_r == CNT_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_r <= CSUM;
`else
                            if (go_r) begin
                                state_r    <= RUN;
                                in_ready_r <= 1'b0;
                            end else begin
                                state_r <= HDR;
                            end
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept_s) begin
                        if (word_s == sum_r) begin
                            if (go_r) begin
                                state_r    <= RUN;
                                in_ready_r <= 1'b0;
                            end else begin
                                state_r <= HDR;
                            end
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= HDR;
                        end
                    end else begin
                        state_r <= CSUM;
                    end
                end
`endif
                RUN: begin
                    state_r    <= RUN;
                    in_ready_r <= 1'b0;
                end
                default: begin
                    state_r <= HDR;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_sel   = mem_sel_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign cpu_hold      = cpu_hold_r;
    assign words_loaded  = words_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign load_error    = err_r;
`else
    assign load_error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level memory model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_hold;
    logic        load_error;
    logic [15:0] words_loaded;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          errors   = 0;
    int          we_count = 0;
    bit          mon_en   = 1'b0;
    bit          err_exp  = 1'b0;
    logic [31:0] imem [DEPTH];
    logic [31:0] dmem [DEPTH];
    logic [31:0] imem_ref [DEPTH];
    logic [31:0] dmem_ref [DEPTH];
    logic [40:0] exp_q [$];
    logic [31:0] payload_q [$];
    logic [40:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory side: every write strobe must be the next one the model predicts
    always @(negedge clock) begin
        if (mon_en && bus.mem_we === 1'b1) begin
            we_count++;
            check("we_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("we_sel",  32'(bus.mem_sel),  32'(mon_e[40]));
                check("we_addr", 32'(bus.mem_addr), 32'(mon_e[39:32]));
                check("we_data", bus.mem_wdata,     mon_e[31:0]);
            end
            if (bus.mem_sel) dmem[bus.mem_addr] = bus.mem_wdata;
            else             imem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_sel",   32'(bus.mem_sel),   32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_cpu_hold",  32'(cpu_hold),      32'd1);
        check("rst_load_err",  32'(load_error),    32'd0);
        check("rst_words",     32'(words_loaded),  32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("rel_cpu_hold",  32'(cpu_hold),      32'd1);
        err_exp = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the word transferred
    task automatic send_word(input logic [31:0] w, input int max_gap);
        int gap;
        int tries;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            @(negedge clock);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tries = 0;
        while (!bus.in_ready && tries < 20) begin
            @(negedge clock);
            tries++;
        end
        if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic tgt, input logic go, input logic [7:0] base,
                              input int max_gap, input bit bad_csum);
        int          n;
        logic [31:0] sum;
        logic [31:0] hdr;
        logic [7:0]  a;
        n   = payload_q.size();
        sum = 32'd0;
        hdr = {tgt, go, 6'd0, 16'(n), base};
        send_word(hdr, max_gap);
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            exp_q.push_back({tgt, a, payload_q[i]});
            if (tgt) dmem_ref[a] = payload_q[i];
            else     imem_ref[a] = payload_q[i];
            sum = sum + payload_q[i];
            send_word(payload_q[i], max_gap);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(bad_csum ? sum + 32'd2 : sum, max_gap);
        if (bad_csum) err_exp = 1'b1;
`else
        if (bad_csum) sum = 32'd0;
`endif
        payload_q.delete();
    endtask

    // Final accept was at the previous posedge: hold drops two edges later
    task automatic check_release(input string tag);
        check({tag, "_hold0"}, 32'(cpu_hold),     32'd1);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        check({tag, "_hold1"}, 32'(cpu_hold),     32'd1);
        check({tag, "_we1"},   32'(bus.mem_we),   32'd0);
        @(negedge clock);
        check({tag, "_hold2"}, 32'(cpu_hold),     32'd0);
    endtask

    logic [31:0] prog [8] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
                              32'h003222B3, 32'h00302023, 32'h07300393, 32'h00000013};

    initial begin
        logic [31:0] va, vb;
        int          c0, n, mism;
        for (int i = 0; i < DEPTH; i++) begin
            imem[i] = 32'd0; dmem[i] = 32'd0; imem_ref[i] = 32'd0; dmem_ref[i] = 32'd0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        @(negedge clock);
        do_reset();

        // Address wrap into DMem, no go
        va = $urandom; vb = $urandom;
        payload_q.push_back(va); payload_q.push_back(vb);
        send_frame(1'b1, 1'b0, 8'hFF, 0, 1'b0);
        @(negedge clock);
        check("wrap_dmem255", dmem[255], va);
        check("wrap_dmem0",   dmem[0],   vb);
        check("wrap_hold",    32'(cpu_hold),     32'd1);
        check("wrap_words",   32'(words_loaded), 32'd2);
        check("wrap_ready",   32'(bus.in_ready), 32'd1);

        // 16-word frame with random source stalls
        c0 = we_count;
        for (int i = 0; i < 16; i++) payload_q.push_back($urandom);
        send_frame(1'($urandom_range(1, 0)), 1'b0, 8'($urandom), 3, 1'b0);
        @(negedge clock);
        check("stall_pulses", 32'(we_count - c0), 32'd16);
        check("stall_words",  32'(words_loaded),  32'd16);
        check("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back random frames, last one longer than the memory depth
        for (int f = 0; f < 6; f++) begin
            n = (f == 5) ? 260 : $urandom_range(20, 0);
            for (int i = 0; i < n; i++) payload_q.push_back($urandom);
            send_frame(1'($urandom_range(1, 0)), 1'b0, 8'($urandom), 0, 1'b0);
        end
        @(negedge clock);
        check("long_words", 32'(words_loaded), 32'd260);
        check("long_hold",  32'(cpu_hold),     32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad trailer: error, go discarded, next header still accepted
        payload_q.push_back(32'hFFFFFFFF); payload_q.push_back(32'h00000002);
        send_frame(1'b1, 1'b1, 8'h40, 0, 1'b1);
        @(negedge clock);
        check("bad_csum_err", 32'(load_error), 32'd1);
        repeat (3) @(negedge clock);
        check("bad_csum_hold",  32'(cpu_hold),     32'd1);
        check("bad_csum_ready", 32'(bus.in_ready), 32'd1);
`endif

        // Basic program go frame into IMem
        for (int i = 0; i < 8; i++) payload_q.push_back(prog[i]);
        send_frame(1'b0, 1'b1, 8'h00, 0, 1'b0);
        check_release("prog");
        for (int i = 0; i < 8; i++) check($sformatf("prog_imem%0d", i), imem[i], prog[i]);
        check("prog_words", 32'(words_loaded), 32'd8);
        check("prog_err",   32'(load_error),   32'(err_exp));

        // RUN ignores the stream
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        repeat (4) @(negedge clock);
        check("run_ready", 32'(bus.in_ready),  32'd0);
        check("run_hold",  32'(cpu_hold),      32'd0);
        check("run_words", 32'(words_loaded),  32'd8);
        bus.in_valid = 1'b0;

        // Zero-length go frame
        do_reset();
        c0 = we_count;
        send_frame(1'b0, 1'b1, 8'h00, 0, 1'b0);
        check_release("zero");
        check("zero_writes", 32'(we_count - c0), 32'd0);
        check("zero_words",  32'(words_loaded),  32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good trailer releases the CPU
        do_reset();
        payload_q.push_back(32'hFFFFFFFF); payload_q.push_back(32'h00000002);
        send_frame(1'b1, 1'b1, 8'h10, 0, 1'b0);
        check_release("good_csum");
        check("good_csum_err", 32'(load_error), 32'd0);
`endif

        // Whole-memory comparison against the frame model
        @(negedge clock);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (imem[i] !== imem_ref[i]) mism++;
            if (dmem[i] !== dmem_ref[i]) mism++;
        end
        check("mem_compare", 32'(mism), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
